// File: rtl/bk_mw_pkg.sv
// Shared types and helpers for the multi-word Brent-Kung addition controller.
package bk_mw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice counter width; a single-slice build still needs one bit.
   function automatic int cnt_width(input int n_words);
      return (n_words <= 1) ? 1 : $clog2(n_words);
   endfunction

endpackage

// File: rtl/bk_multiword_adder_top.sv
// Integration wrapper: multi-word controller plus its Brent-Kung slice adder.
// Optional BK_MW_SIGNED_OVF_EN exposes the signed overflow flag.
module bk_multiword_adder_top #(
   parameter int ADDER_SIZE = 64,
   parameter int N_WORDS    = 4,
   localparam int WIDE      = ADDER_SIZE * N_WORDS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WIDE-1:0] in_op1,
   input  logic [WIDE-1:0] in_op2,
   input  logic            in_cin,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WIDE-1:0] out_res,
   output logic            out_cout
`ifdef BK_MW_SIGNED_OVF_EN
   ,
   output logic            out_ovf
`endif
);

   logic [ADDER_SIZE-1:0] add_op1;
   logic [ADDER_SIZE-1:0] add_op2;
   logic [ADDER_SIZE-1:0] add_res;
   logic                  add_cin;
   logic                  add_cout;

   bk_multiword_add_ctrl #(.ADDER_SIZE(ADDER_SIZE), .N_WORDS(N_WORDS)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op1    (in_op1),
      .in_op2    (in_op2),
      .in_cin    (in_cin),
      .add_op1   (add_op1),
      .add_op2   (add_op2),
      .add_cin   (add_cin),
      .add_res   (add_res),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_cout  (out_cout)
`ifdef BK_MW_SIGNED_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   brent_kung_adder_nbit #(.N(ADDER_SIZE)) u_adder (
      .in_op1  (add_op1),
      .in_op2  (add_op2),
      .cin     (add_cin),
      .out_res (add_res),
      .cout    (add_cout)
   );

endmodule

// File: rtl/brent_kung_adder_nbit.sv
// Combinational N-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
module brent_kung_adder_nbit #(
   parameter int N = 64
) (
   input  logic [N-1:0] in_op1,
   input  logic [N-1:0] in_op2,
   input  logic         cin,
   output logic [N-1:0] out_res,
   output logic         cout
);

   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N-1:0] grp_g;
   logic [N-1:0] grp_p;

   always_comb begin
      gen   = in_op1 & in_op2;
      prop  = in_op1 ^ in_op2;
      grp_g = gen;
      grp_p = prop;
      // Up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes.
      for (int d = 1; d < N; d = d * 2) begin
         for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
            grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
            grp_p[i] = grp_p[i] & grp_p[i-d];
         end
      end
      for (int d = N / 4; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
            grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
            grp_p[i] = grp_p[i] & grp_p[i-d];
         end
      end
      out_res[0] = prop[0] ^ cin;
      for (int i = 1; i < N; i++) begin
         out_res[i] = prop[i] ^ (grp_g[i-1] | (grp_p[i-1] & cin));
      end
      cout = grp_g[N-1] | (grp_p[N-1] & cin);
   end

endmodule

// File: rtl/bk_multiword_add_ctrl.sv
// Sequential wide adder controller: streams ADDER_SIZE slices through an external adder.
// Optional BK_MW_SIGNED_OVF_EN adds a registered two's-complement overflow output.
module bk_multiword_add_ctrl
   import bk_mw_pkg::*;
#(
   parameter int ADDER_SIZE = 64,
   parameter int N_WORDS    = 4,
   localparam int WIDE      = ADDER_SIZE * N_WORDS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDE-1:0]       in_op1,
   input  logic [WIDE-1:0]       in_op2,
   input  logic                  in_cin,
   output logic [ADDER_SIZE-1:0] add_op1,
   output logic [ADDER_SIZE-1:0] add_op2,
   output logic                  add_cin,
   input  logic [ADDER_SIZE-1:0] add_res,
   input  logic                  add_cout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDE-1:0]       out_res,
   output logic                  out_cout
`ifdef BK_MW_SIGNED_OVF_EN
   ,
   output logic                  out_ovf
`endif
);

   localparam int CNT_W = cnt_width(N_WORDS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDE-1:0]  op1_q;
   logic [WIDE-1:0]  op2_q;
   logic [WIDE-1:0]  res_q;
   logic [WIDE-1:0]  res_shift;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             last_slice;

   assign add_op1    = op1_q[ADDER_SIZE-1:0];
   assign add_op2    = op2_q[ADDER_SIZE-1:0];
   assign add_cin    = carry_q;
   assign out_res    = res_q;
   assign out_cout   = carry_q;
   assign last_slice = (cnt_q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            accept   = in_valid && !rst;
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            if (last_slice) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result fills from the top so the first (least significant) slice ends up at bit 0.
   always_comb begin
      res_shift = res_q >> ADDER_SIZE;
      res_shift[WIDE-1 -: ADDER_SIZE] = add_res;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op1_q   <= '0;
         op2_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         op1_q   <= in_op1;
         op2_q   <= in_op2;
         carry_q <= in_cin;
         cnt_q   <= '0;
      end else if (state == RUN) begin
         op1_q   <= op1_q >> ADDER_SIZE;
         op2_q   <= op2_q >> ADDER_SIZE;
         res_q   <= res_shift;
         carry_q <= add_cout;
         cnt_q   <= last_slice ? cnt_q : cnt_q + 1'b1;
      end
   end

`ifdef BK_MW_SIGNED_OVF_EN
   // Carry into the MSB is a^b^sum at that bit; overflow when it differs from carry out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_ovf <= 1'b0;
      end else if (state == RUN && last_slice) begin
         out_ovf <= add_op1[ADDER_SIZE-1] ^ add_op2[ADDER_SIZE-1] ^
                    add_res[ADDER_SIZE-1] ^ add_cout;
      end
   end
`endif

endmodule

// File: tb/tb_bk_multiword_add_ctrl.sv
// Directed and random bench for bk_multiword_add_ctrl with an 8-bit Brent-Kung slice adder.
module tb_bk_multiword_add_ctrl;

   localparam int AS = 8;
   localparam int NW = 4;
   localparam int W  = AS * NW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_op1 = '0;
   logic [W-1:0]  in_op2 = '0;
   logic          in_cin = 1'b0;
   logic [AS-1:0] add_op1;
   logic [AS-1:0] add_op2;
   logic          add_cin;
   logic [AS-1:0] add_res;
   logic          add_cout;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_res;
   logic          out_cout;
`ifdef BK_MW_SIGNED_OVF_EN
   logic          out_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bk_multiword_add_ctrl #(.ADDER_SIZE(AS), .N_WORDS(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op1    (in_op1),
      .in_op2    (in_op2),
      .in_cin    (in_cin),
      .add_op1   (add_op1),
      .add_op2   (add_op2),
      .add_cin   (add_cin),
      .add_res   (add_res),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_cout  (out_cout)
`ifdef BK_MW_SIGNED_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   brent_kung_adder_nbit #(.N(AS)) u_adder (
      .in_op1  (add_op1),
      .in_op2  (add_op2),
      .cin     (add_cin),
      .out_res (add_res),
      .cout    (add_cout)
   );

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      in_op1   = a;
      in_op2   = b;
      in_cin   = c;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Returns at the negedge where out_valid is first seen; lat counts clock edges after accept.
   task automatic get_result(output int lat);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL result_wait: out_valid=%b required 1 within 20 cycles", out_valid);
      end
   endtask

   task automatic ack(input int hold);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({in_ready, out_valid, out_cout, out_res} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b cout=%b res=%h required all 0",
                  in_ready, out_valid, out_cout, out_res);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_carry_ripple();
      int lat;
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      get_result(lat);
      n_checks++;
      if (lat !== NW) begin
         n_fail++;
         $display("FAIL ripple_latency: got %0d cycles required %0d", lat, NW);
      end
      n_checks++;
      if ({out_cout, out_res} !== {1'b1, 32'h0000_0000}) begin
         n_fail++;
         $display("FAIL ripple_result: cout=%b res=%h required cout=1 res=00000000", out_cout, out_res);
      end
      ack(0);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ripple_valid_drop: out_valid=%b required 0", out_valid);
      end
   endtask

   // out_ready is held high from before the request, so it must not matter outside DONE.
   task automatic test_basic_cin();
      int lat;
      out_ready = 1'b1;
      send(32'h1234_5678, 32'h1111_1111, 1'b1);
      get_result(lat);
      n_checks++;
      if ({out_cout, out_res} !== {1'b0, 32'h2345_678A} || lat !== NW) begin
         n_fail++;
         $display("FAIL basic_cin: cout=%b res=%h lat=%0d required cout=0 res=2345678a lat=%0d",
                  out_cout, out_res, lat, NW);
      end
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat;
      send(32'h0F0F_F0F0, 32'h1010_1010, 1'b0);
      get_result(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, in_ready, out_cout, out_res} !== {1'b1, 1'b0, 1'b0, 32'h1F20_0100}) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b cout=%b res=%h required 1 0 0 1f200100",
                     i, out_valid, in_ready, out_cout, out_res);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL backpressure_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
      end
      send(32'h8000_0001, 32'h8000_0001, 1'b0);
      get_result(lat);
      n_checks++;
      if ({out_cout, out_res} !== {1'b1, 32'h0000_0002}) begin
         n_fail++;
         $display("FAIL backpressure_next: cout=%b res=%h required cout=1 res=00000002", out_cout, out_res);
      end
      ack(0);
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int seen = 0;
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_res} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: vld=%b rdy=%b res=%h required all 0", out_valid, in_ready, out_res);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_ready: in_ready=%b required 1", in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midrun_no_valid: out_valid seen %0d cycles required 0", seen);
      end
      send(32'h0000_0001, 32'h0000_0001, 1'b0);
      get_result(lat);
      n_checks++;
      if ({out_cout, out_res} !== {1'b0, 32'h0000_0002}) begin
         n_fail++;
         $display("FAIL midrun_after: cout=%b res=%h required cout=0 res=00000002", out_cout, out_res);
      end
      ack(1);
   endtask

   task automatic test_signed_ovf();
      int lat;
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      get_result(lat);
      n_checks++;
      if ({out_cout, out_res} !== {1'b0, 32'h8000_0000}) begin
         n_fail++;
         $display("FAIL ovf_pos_result: cout=%b res=%h required cout=0 res=80000000", out_cout, out_res);
      end
`ifdef BK_MW_SIGNED_OVF_EN
      n_checks++;
      if (out_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_pos_flag: out_ovf=%b required 1", out_ovf);
      end
`endif
      ack(0);
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      get_result(lat);
      n_checks++;
      if ({out_cout, out_res} !== {1'b1, 32'h0000_0000}) begin
         n_fail++;
         $display("FAIL ovf_neg_result: cout=%b res=%h required cout=1 res=00000000", out_cout, out_res);
      end
`ifdef BK_MW_SIGNED_OVF_EN
      n_checks++;
      if (out_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_neg_flag: out_ovf=%b required 0", out_ovf);
      end
`endif
      ack(0);
   endtask

   task automatic test_random_soak();
      int          lat;
      int          responses = 0;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W:0]   exp_sum;
      for (int n = 0; n < 1000; n++) begin
         a = $urandom;
         b = $urandom;
         c = 1'($urandom_range(0, 1));
         exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(a, b, c);
         get_result(lat);
         if (out_valid) responses++;
         n_checks++;
         if ({out_cout, out_res} !== exp_sum || lat !== NW) begin
            n_fail++;
            $display("FAIL soak[%0d]: %h+%h+%b got cout=%b res=%h lat=%0d required %h lat=%0d",
                     n, a, b, c, out_cout, out_res, lat, exp_sum, NW);
         end
`ifdef BK_MW_SIGNED_OVF_EN
         n_checks++;
         if (out_ovf !== ((a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]))) begin
            n_fail++;
            $display("FAIL soak_ovf[%0d]: out_ovf=%b for %h+%h+%b", n, out_ovf, a, b, c);
         end
`endif
         ack($urandom_range(0, 3));
      end
      n_checks++;
      if (responses !== 1000) begin
         n_fail++;
         $display("FAIL soak_count: %0d responses required 1000", responses);
      end
   endtask

   initial begin
      test_reset();
      test_carry_ripple();
      test_basic_cin();
      test_backpressure();
      test_reset_mid_run();
      test_signed_ovf();
      test_random_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
